// File: rtl/retire_trace_buffer.sv
// Retire-event capture block: samples one retire record per cycle into a
// first-word-fall-through FIFO for a drain port, keeps cycle/instruction
// counters, and stops capture on halt or on the cycle-limit watchdog.
module retire_trace_buffer #(
  parameter int unsigned DW         = 16,
  parameter int unsigned RW         = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000,
  localparam int unsigned REC_W     = 4 + RW + 5 * DW,
  localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ret_valid,
  input  logic [DW-1:0]    ret_pc,
  input  logic [DW-1:0]    ret_inst,
  input  logic             ret_regwr,
  input  logic [RW-1:0]    ret_reg,
  input  logic [DW-1:0]    ret_wdata,
  input  logic             ret_memrd,
  input  logic             ret_memwr,
  input  logic [DW-1:0]    ret_maddr,
  input  logic [DW-1:0]    ret_mdata,
  input  logic             ret_halt,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic             overflow,
  output logic             halted,
  output logic             timeout,
  output logic             done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  // Count value at which the expiring edge fires; unused when MAX_CYCLES is 0.
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(MAX_CYCLES - 1);

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [REC_W-1:0] newRec;
  logic             active;
  logic             sample;
  logic             full;
  logic             pop;
  logic             push;
  logic             haltHit;
  logic             wdHit;

  // Capture qualification, FIFO handshakes and derived outputs.
  always_comb begin
    newRec   = {ret_halt, ret_memwr, ret_memrd, ret_regwr, ret_reg,
                ret_pc, ret_inst, ret_wdata, ret_maddr, ret_mdata};
    active   = !halted && !timeout;
    sample   = ret_valid && active;
    full     = (level == LVL_W'(DEPTH));
    rd_valid = (level != '0);
    pop      = rd_valid && rd_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    push     = sample && (!full || pop);
    haltHit  = sample && ret_halt;
    wdHit    = (MAX_CYCLES != 0) && active && (cycle_count == WdLast);
    done     = (halted || timeout) && !rd_valid;
    // Empty FIFO presents zero rather than stale storage.
    rd_data  = rd_valid ? mem[rdPtr] : '0;
  end

  // Record storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= newRec;
    end
  end

  // Pointers, occupancy, counters and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      level       <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      overflow    <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (!push && pop) begin
        level <= level - 1'b1;
      end
      if (active && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 1'b1;
      end
      // Dropped records still count as retired instructions.
      if (sample && (inst_count != '1)) begin
        inst_count <= inst_count + 1'b1;
      end
      if (sample && !push) begin
        overflow <= 1'b1;
      end
      // Halt wins over a watchdog expiry on the same edge.
      if (haltHit) begin
        halted <= 1'b1;
      end else if (wdHit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
